// File: rtl/uart_tx_cfg_baud.sv
// 8N1 UART transmitter with a run-time bit period latched per frame; TX/busy/tx_done registered (one cycle behind FSM).
// Optional even-parity bit enabled by defining UART_TX_PARITY_EN; trmt is ignored while a frame is in flight.
module uart_tx_cfg_baud (
  input  logic        clk,
  input  logic        rst,
  input  logic        trmt,
  input  logic [7:0]  tx_data,
  input  logic [15:0] baud_cnt,
  output logic        TX,
  output logic        busy,
  output logic        tx_done
);

`ifdef UART_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = 11;
`else
  localparam int unsigned FRAME_LEN = 10;
`endif
  localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

  typedef enum logic {IDLE, XMIT} state_e;

  state_e                 state_q, state_d;
  logic [FRAME_LEN-1:0]   shift_reg_q, shift_reg_d;
  logic [15:0]            period_q, period_d;
  logic [15:0]            baud_q, baud_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic                   tx_q, tx_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   shift;
  logic [15:0]            eff_period;
  logic [FRAME_LEN-1:0]   frame;

  // Periods below 2 cannot produce a distinct shift cycle, so clamp them.
  assign eff_period = (baud_cnt < 16'd2) ? 16'd2 : baud_cnt;

`ifdef UART_TX_PARITY_EN
  assign frame = {1'b1, ^tx_data, tx_data, 1'b0};
`else
  assign frame = {1'b1, tx_data, 1'b0};
`endif

  always_comb begin
    state_d     = state_q;
    shift_reg_d = shift_reg_q;
    period_d    = period_q;
    baud_d      = baud_q;
    bit_cnt_d   = bit_cnt_q;
    shift       = 1'b0;
    busy_d      = (state_q == XMIT);
    tx_d        = (state_q == XMIT) ? shift_reg_q[0] : 1'b1;
    // busy_q still high while the FSM already sits in IDLE marks the frame end.
    done_d      = done_q | (busy_q && (state_q == IDLE));

    case (state_q)
      IDLE: begin
        if (trmt) begin
          state_d     = XMIT;
          shift_reg_d = frame;
          period_d    = eff_period;
          baud_d      = eff_period;
          bit_cnt_d   = 4'd0;
          done_d      = 1'b0;
        end
      end
      XMIT: begin
        shift = (baud_q == 16'd1);
        if (shift) begin
          shift_reg_d = {1'b1, shift_reg_q[FRAME_LEN-1:1]};
          baud_d      = period_q;
          bit_cnt_d   = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q - 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_reg_q <= '1;
      period_q    <= 16'd0;
      baud_q      <= 16'd0;
      bit_cnt_q   <= 4'd0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_reg_q <= shift_reg_d;
      period_q    <= period_d;
      baud_q      <= baud_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_q        <= tx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign TX      = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_cfg_baud.sv
// Bench for uart_tx_cfg_baud: directed scenarios plus random traffic, every cycle checked
// against a frame-timing model (bit k of a frame accepted at edge N spans edges N+1+kP..N+(k+1)P).
module tb_uart_tx_cfg_baud;

`ifdef UART_TX_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        trmt = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic [15:0] baud_cnt = 16'd16;
  logic        TX, busy, tx_done;

  int n_checks = 0;
  int n_fail   = 0;
  int t        = 0;

  // Reference model state: the most recently accepted frame.
  bit          active = 1'b0;
  int          n_acc  = 0;
  int          per    = 2;
  logic [10:0] frm    = '1;
  logic        exp_tx, exp_busy, exp_done;

  uart_tx_cfg_baud dut (
    .clk      (clk),
    .rst      (rst),
    .trmt     (trmt),
    .tx_data  (tx_data),
    .baud_cnt (baud_cnt),
    .TX       (TX),
    .busy     (busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, t, obs, exp);
    end
  endtask

  function automatic logic [10:0] build_frame(input logic [7:0] d);
    logic [10:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) f[1+i] = d[i];
    if (F == 11) f[9] = ^d;
    f[F-1] = 1'b1;
    return f;
  endfunction

  task automatic model_edge();
    if (rst) begin
      active = 1'b0;
    end else if (trmt && (!active || t > n_acc + F*per)) begin
      active = 1'b1;
      n_acc  = t;
      per    = (baud_cnt < 16'd2) ? 2 : int'(baud_cnt);
      frm    = build_frame(tx_data);
    end
    if (active && t >= n_acc + 1 && t <= n_acc + F*per) begin
      exp_busy = 1'b1;
      exp_tx   = frm[(t - n_acc - 1) / per];
    end else begin
      exp_busy = 1'b0;
      exp_tx   = 1'b1;
    end
    exp_done = active && (t > n_acc + F*per);
  endtask

  task automatic tick();
    @(posedge clk);
    t++;
    model_edge();
    @(negedge clk);
    check("tx",      {31'd0, TX},      {31'd0, exp_tx});
    check("busy",    {31'd0, busy},    {31'd0, exp_busy});
    check("tx_done", {31'd0, tx_done}, {31'd0, exp_done});
  endtask

  task automatic send(input logic [7:0] d, input logic [15:0] p);
    trmt     = 1'b1;
    tx_data  = d;
    baud_cnt = p;
    tick();
    trmt = 1'b0;
  endtask

  initial begin
    int rise;
    logic [7:0] bytes [3];

    // Reset held with trmt asserted: no frame may start.
    rst = 1'b1; trmt = 1'b1; tx_data = 8'hFF; baud_cnt = 16'd4;
    repeat (3) tick();
    rst = 1'b0; trmt = 1'b0;
    repeat (4) tick();

    // 0xA5 at 16 cycles per bit, with explicit completion latency.
    send(8'hA5, 16'd16);
    rise = -1;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (tx_done === 1'b1 && rise < 0) rise = k;
    end
    check("done_latency", rise, 1 + F*16);

    // Mid-frame trmt with new data/period is ignored and not queued.
    send(8'hC3, 16'd8);
    repeat (30) tick();
    trmt = 1'b1; tx_data = 8'h12; baud_cnt = 16'd4;
    tick();
    trmt = 1'b0;
    repeat (F*8 + 40) tick();

    // Reset in the middle of data bit 3, then a clean 0x5A frame.
    send(8'h96, 16'd10);
    repeat (44) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) tick();
    send(8'h5A, 16'd6);
    repeat (F*6 + 10) tick();

    // Minimum-period clamp for 0 and 1.
    send(8'h81, 16'd0);
    repeat (F*2 + 4) tick();
    send(8'h7E, 16'd1);
    repeat (F*2 + 4) tick();

    // Back-to-back frames at the receiver's nominal period.
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h3C;
    for (int b = 0; b < 3; b++) begin
      send(bytes[b], 16'h01B2);
      repeat (F*16'h01B2) tick();
    end
    repeat (5) tick();

    // Random traffic: frequent requests, occasional resets, short periods.
    for (int c = 0; c < 4000; c++) begin
      rst      = ($urandom % 300) == 0;
      trmt     = ($urandom % 6) == 0;
      tx_data  = 8'($urandom);
      baud_cnt = 16'($urandom_range(0, 12));
      tick();
    end
    rst = 1'b0; trmt = 1'b0;
    repeat (F*12 + 5) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
